// File: rtl/arith_unit_seq.sv
// arith_unit_seq: sequential add/sub/mul/div unit with valid/ready handshake and registered flags
// Optional divider enabled by defining ARITH_DIV_EN; otherwise op=11 flags dz in one cycle.
module arith_unit_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_dz
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state;
  logic [1:0] op_r;
  logic [WIDTH-1:0] b_r, bb, lo_nx, hi_nx, dz_lo, dz_hi;
  logic [2*WIDTH-1:0] p, p_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] sum, madd;
  logic dz, fin, c_nx, v_nx, z_nx, n_nx;
`ifdef ARITH_DIV_EN
  logic [WIDTH:0] t;
  logic ge;
  logic [WIDTH-1:0] rem;
`endif
  // p holds {0, a} at start: multiplier/dividend shifts out of the low half
  always_comb begin
    bb = op_r[0] ? ~b_r : b_r;
    sum = {1'b0, p[WIDTH-1:0]} + {1'b0, bb} + {{WIDTH{1'b0}}, op_r[0]};
    madd = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, b_r} : '0);
`ifdef ARITH_DIV_EN
    t = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    ge = t >= {1'b0, b_r};
    rem = ge ? WIDTH'(t - {1'b0, b_r}) : t[WIDTH-1:0];
    p_nx = op_r[0] ? {rem, p[WIDTH-2:0], ge} : {madd, p[WIDTH-1:1]};
    dz = op_r == 2'b11 && b_r == '0;
    dz_lo = '1;
    dz_hi = p[WIDTH-1:0];
`else
    p_nx = {madd, p[WIDTH-1:1]};
    dz = op_r == 2'b11;
    dz_lo = '0;
    dz_hi = '0;
`endif
    fin = !op_r[1] || dz || cnt == CW'(WIDTH);
    lo_nx = !op_r[1] ? sum[WIDTH-1:0] : dz ? dz_lo : p[WIDTH-1:0];
    hi_nx = !op_r[1] ? '0 : dz ? dz_hi : p[2*WIDTH-1:WIDTH];
    c_nx = !op_r[1] ? sum[WIDTH] : op_r == 2'b10 && hi_nx != '0;
    v_nx = !op_r[1] && p[WIDTH-1] == bb[WIDTH-1] && sum[WIDTH-1] != p[WIDTH-1];
    z_nx = !dz && {hi_nx, lo_nx} == '0;
    n_nx = !op_r[1] && sum[WIDTH-1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      op_r <= '0;
      b_r <= '0;
      p <= '0;
      cnt <= '0;
      result_lo <= '0;
      result_hi <= '0;
      {flag_c, flag_v, flag_z, flag_n, flag_dz} <= '0;
    end else
      case (state)
        IDLE: if (in_valid) begin
          op_r <= op;
          b_r <= b;
          p <= {{WIDTH{1'b0}}, a};
          cnt <= '0;
          in_ready <= 1'b0;
          state <= EXEC;
        end
        EXEC: if (fin) begin
          result_lo <= lo_nx;
          result_hi <= hi_nx;
          {flag_c, flag_v, flag_z, flag_n, flag_dz} <= {c_nx, v_nx, z_nx, n_nx, dz};
          out_valid <= 1'b1;
          state <= DONE;
        end else begin
          p <= p_nx;
          cnt <= cnt + CW'(1);
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule
